// File: rtl/cc_decoder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cc_decoder_sequencer
// Description : Registered one-hot select driver. It holds a loaded code
//               (DIRECT) or walks codes 1..OUT_WIDTH at a programmable rate
//               (SCAN).
// Revision    : 1.0 - initial release
// ============================================================================
module cc_decoder_sequencer #(
  parameter int SEL_WIDTH = 4,
  parameter int OUT_WIDTH = 12,
  parameter int STEP_DIV  = 4
) (
  input  logic                 CC_DECODERSEQ_CLOCK_50,
  input  logic                 CC_DECODERSEQ_RESET_InHigh,
  input  logic                 CC_DECODERSEQ_mode_In,
  input  logic                 CC_DECODERSEQ_load_In,
  input  logic                 CC_DECODERSEQ_hold_In,
  input  logic [SEL_WIDTH-1:0] CC_DECODERSEQ_selection_InBUS,
  output logic [OUT_WIDTH-1:0] CC_DECODERSEQ_datadecoder_OutBUS,
  output logic [SEL_WIDTH-1:0] CC_DECODERSEQ_code_OutBUS,
  output logic                 CC_DECODERSEQ_valid_Out,
  output logic                 CC_DECODERSEQ_wrap_Out,
  output logic                 CC_DECODERSEQ_error_Out
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [SEL_WIDTH-1:0] c_code_max   = SEL_WIDTH'(OUT_WIDTH);
  localparam logic [SEL_WIDTH-1:0] c_code_one   = SEL_WIDTH'(1);
  localparam logic [PRESC_W-1:0]   c_presc_last = PRESC_W'(STEP_DIV - 1);
  localparam logic [PRESC_W-1:0]   c_presc_one  = PRESC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SEL_WIDTH-1:0]   r_code;
  logic [PRESC_W-1:0]     r_presc;
  logic                   r_wrap;
  logic                   r_error;
  logic                   r_valid;
  logic [OUT_WIDTH-1:0]   r_out;

  state_t                 w_state_nxt;
  logic [SEL_WIDTH-1:0]   w_code_nxt;
  logic [PRESC_W-1:0]     w_presc_nxt;
  logic                   w_wrap_nxt;
  logic                   w_error_nxt;
  logic                   w_scan_run;
  logic                   w_sel_zero;
  logic                   w_sel_oor;
  logic [OUT_WIDTH-1:0]   w_out_nxt;

  assign w_sel_zero = (CC_DECODERSEQ_selection_InBUS == '0);
  assign w_sel_oor  = (CC_DECODERSEQ_selection_InBUS > c_code_max);

  always_ff @(posedge CC_DECODERSEQ_CLOCK_50) begin
    if (CC_DECODERSEQ_RESET_InHigh) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_error <= 1'b0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_presc <= w_presc_nxt;
      r_wrap  <= w_wrap_nxt;
      r_error <= w_error_nxt;
      r_valid <= (w_code_nxt != '0);
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_presc_nxt = r_presc;
    w_wrap_nxt  = 1'b0;
    w_error_nxt = r_error;
    w_scan_run  = 1'b0;
    w_out_nxt   = '0;

    if (CC_DECODERSEQ_load_In) begin
      if (w_sel_oor) begin
        w_error_nxt = 1'b1;
      end
      if (CC_DECODERSEQ_mode_In) begin
        w_state_nxt = ST_SCAN;
        w_code_nxt  = (w_sel_zero || w_sel_oor) ? c_code_one : CC_DECODERSEQ_selection_InBUS;
        w_presc_nxt = '0;
      end else if (w_sel_zero) begin
        w_state_nxt = ST_IDLE;
        w_code_nxt  = '0;
      end else if (!w_sel_oor) begin
        w_state_nxt = ST_DIRECT;
        w_code_nxt  = CC_DECODERSEQ_selection_InBUS;
      end else begin
        // A rejected direct load leaves a running scan undisturbed.
        w_scan_run = (r_state == ST_SCAN);
      end
    end else begin
      w_scan_run = (r_state == ST_SCAN);
    end

    if (w_scan_run && !CC_DECODERSEQ_hold_In) begin
      if (r_presc == c_presc_last) begin
        w_presc_nxt = '0;
        if (r_code == c_code_max) begin
          w_code_nxt = c_code_one;
          w_wrap_nxt = 1'b1;
        end else begin
          w_code_nxt = r_code + c_code_one;
        end
      end else begin
        w_presc_nxt = r_presc + c_presc_one;
      end
    end

    for (int i = 0; i < OUT_WIDTH; i++) begin
      w_out_nxt[i] = (w_code_nxt == SEL_WIDTH'(i + 1));
    end
  end

  assign CC_DECODERSEQ_datadecoder_OutBUS = r_out;
  assign CC_DECODERSEQ_code_OutBUS        = r_code;
  assign CC_DECODERSEQ_valid_Out          = r_valid;
  assign CC_DECODERSEQ_wrap_Out           = r_wrap;
  assign CC_DECODERSEQ_error_Out          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cc_decoder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_decoder_sequencer
// Description : Randomized bench for cc_decoder_sequencer. It runs a
//               STEP_DIV=4 and a STEP_DIV=1 instance against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_decoder_sequencer;

  logic       clk;
  logic       rst;
  logic       load;
  logic       mode;
  logic       hold;
  logic [3:0] sel;

  logic [11:0] out_bus [2];
  logic [3:0]  code    [2];
  logic        valid   [2];
  logic        wrap    [2];
  logic        err     [2];

  int n_pass  = 0;
  int n_total = 0;

  // Model state, one slot per instance: 0 = idle, 1 = direct, 2 = scan.
  int m_st   [2];
  int m_code [2];
  int m_rem  [2];
  int m_wrap [2];
  int m_err  [2];
  int m_div  [2] = '{4, 1};
  bit m_live = 1'b0;

  cc_decoder_sequencer #(.SEL_WIDTH(4), .OUT_WIDTH(12), .STEP_DIV(4)) dut0 (
    .CC_DECODERSEQ_CLOCK_50          (clk),
    .CC_DECODERSEQ_RESET_InHigh      (rst),
    .CC_DECODERSEQ_mode_In           (mode),
    .CC_DECODERSEQ_load_In           (load),
    .CC_DECODERSEQ_hold_In           (hold),
    .CC_DECODERSEQ_selection_InBUS   (sel),
    .CC_DECODERSEQ_datadecoder_OutBUS(out_bus[0]),
    .CC_DECODERSEQ_code_OutBUS       (code[0]),
    .CC_DECODERSEQ_valid_Out         (valid[0]),
    .CC_DECODERSEQ_wrap_Out          (wrap[0]),
    .CC_DECODERSEQ_error_Out         (err[0])
  );

  cc_decoder_sequencer #(.SEL_WIDTH(4), .OUT_WIDTH(12), .STEP_DIV(1)) dut1 (
    .CC_DECODERSEQ_CLOCK_50          (clk),
    .CC_DECODERSEQ_RESET_InHigh      (rst),
    .CC_DECODERSEQ_mode_In           (mode),
    .CC_DECODERSEQ_load_In           (load),
    .CC_DECODERSEQ_hold_In           (hold),
    .CC_DECODERSEQ_selection_InBUS   (sel),
    .CC_DECODERSEQ_datadecoder_OutBUS(out_bus[1]),
    .CC_DECODERSEQ_code_OutBUS       (code[1]),
    .CC_DECODERSEQ_valid_Out         (valid[1]),
    .CC_DECODERSEQ_wrap_Out          (wrap[1]),
    .CC_DECODERSEQ_error_Out         (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic scan_advance(input int k);
    if (!hold) begin
      m_rem[k]--;
      if (m_rem[k] == 0) begin
        m_rem[k] = m_div[k];
        if (m_code[k] == 12) begin
          m_code[k] = 1;
          m_wrap[k] = 1;
        end else begin
          m_code[k] = m_code[k] + 1;
        end
      end
    end
  endtask

  task automatic model_step(input int k);
    int s;
    bit oor;
    s   = int'(sel);
    oor = (s > 12);
    if (rst) begin
      m_st[k] = 0; m_code[k] = 0; m_rem[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end else begin
      m_wrap[k] = 0;
      if (load) begin
        if (oor) m_err[k] = 1;
        if (mode) begin
          m_st[k]   = 2;
          m_code[k] = (s >= 1 && !oor) ? s : 1;
          m_rem[k]  = m_div[k];
        end else if (s == 0) begin
          m_st[k] = 0; m_code[k] = 0;
        end else if (!oor) begin
          m_st[k] = 1; m_code[k] = s;
        end else if (m_st[k] == 2) begin
          scan_advance(k);
        end
      end else if (m_st[k] == 2) begin
        scan_advance(k);
      end
    end
  endtask

  // Single compare process: advance the model on each edge, check 1 ns later.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (rst) m_live = 1'b1;
    #1;
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_out", k), int'(out_bus[k]),
            (m_code[k] == 0) ? 0 : (1 << (m_code[k] - 1)));
        chk($sformatf("m%0d_code", k), int'(code[k]), m_code[k]);
        chk($sformatf("m%0d_valid", k), int'(valid[k]), (m_code[k] != 0) ? 1 : 0);
        chk($sformatf("m%0d_wrap", k), int'(wrap[k]), m_wrap[k]);
        chk($sformatf("m%0d_err", k), int'(err[k]), m_err[k]);
      end
    end
  end

  task automatic cyc(input bit r, input bit l, input bit m, input bit h, input int s);
    @(negedge clk);
    rst = r; load = l; mode = m; hold = h; sel = 4'(s);
    @(posedge clk);
    #2;
  endtask

  task automatic cyc_rand();
    cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15), 1'($urandom),
        ($urandom_range(0, 99) < 20), int'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; hold = 1'b0; sel = 4'd0;
    cyc(1, 0, 0, 0, 0);

    // T1: activity, then two reset cycles
    for (int i = 0; i < 20; i++) cyc_rand();
    cyc(1, 1, 1, 0, 13);
    cyc(1, 0, 0, 0, 0);
    chk("t1_out", int'(out_bus[0]), 'h000);
    chk("t1_code", int'(code[0]), 0);
    chk("t1_valid", int'(valid[0]), 0);
    chk("t1_wrap", int'(wrap[0]), 0);
    chk("t1_err", int'(err[0]), 0);

    // T2
    cyc(0, 1, 0, 0, 5);
    chk("t2_out", int'(out_bus[0]), 'h010);
    chk("t2_code", int'(code[0]), 5);
    chk("t2_valid", int'(valid[0]), 1);
    cyc(0, 1, 0, 0, 0);
    chk("t2_out_zero", int'(out_bus[0]), 'h000);
    chk("t2_valid_zero", int'(valid[0]), 0);

    // T3: out-of-range load in DIRECT
    cyc(0, 1, 0, 0, 3);
    cyc(0, 1, 0, 0, 13);
    chk("t3_out_held", int'(out_bus[0]), 'h004);
    chk("t3_err", int'(err[0]), 1);
    cyc(0, 1, 0, 0, 7);
    chk("t3_out_new", int'(out_bus[0]), 'h040);
    chk("t3_err_sticky", int'(err[0]), 1);
    cyc(1, 0, 0, 0, 0);
    chk("t3_err_clear", int'(err[0]), 0);

    // T4: scan from 11 through the wrap
    cyc(0, 1, 1, 0, 11);
    chk("t4_first", int'(out_bus[0]), 'h400);
    chk("t4_entry_wrap", int'(wrap[0]), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t4_c11", int'(out_bus[0]), 'h400);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t4_c12", int'(out_bus[0]), 'h800);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t4_wrap_out", int'(out_bus[0]), 'h001);
    chk("t4_wrap_pulse", int'(wrap[0]), 1);
    cyc(0, 0, 0, 0, 0);
    chk("t4_wrap_end", int'(wrap[0]), 0);

    // T5: hold freezes the prescaler
    cyc(0, 1, 1, 0, 2);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t5_frozen", int'(out_bus[0]), 'h002);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t5_resume", int'(out_bus[0]), 'h002);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t5_step", int'(out_bus[0]), 'h004);

    // T6: reset beats load
    cyc(0, 1, 1, 0, 5);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 7);
    chk("t6_out", int'(out_bus[0]), 'h000);
    chk("t6_code", int'(code[0]), 0);
    chk("t6_valid", int'(valid[0]), 0);

    // STEP_DIV=1 instance: one code per cycle, wrap every 12
    cyc(0, 1, 1, 0, 0);
    chk("d1_entry", int'(code[1]), 1);
    chk("d1_entry_wrap", int'(wrap[1]), 0);
    for (int i = 2; i <= 12; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("d1_walk", int'(code[1]), i);
    end
    cyc(0, 0, 0, 0, 0);
    chk("d1_wrap_code", int'(code[1]), 1);
    chk("d1_wrap_pulse", int'(wrap[1]), 1);

    for (int i = 0; i < 3000; i++) cyc_rand();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
